hct74163: RTL and testbench
===========================

// Module: hct74163
// PURPOSE
// - Presettable synchronous binary counter (74HCT163 model), WIDTH bits.
// - Sits directly downstream of the hct74157 2:1 mux: the mux output Y drives D, so the
//   counter either counts or loads one of two mux-selected values (e.g. PC increment vs jump).
// - Cascadable via CET/TC ripple-enable; synchronous active-low clear.
// PARAMETERS
// - WIDTH      4    counter width in bits (>=1); 4 matches the physical chip
// - TPD_CP_Q   20   ns, CP rising edge -> Q valid (timing build only)
// - TPD_CP_TC  24   ns, CP rising edge -> TC valid (timing build only)
// - TPD_CET_TC 14   ns, CET change -> TC valid (timing build only)
// PORTS
// - CP    in   1      clock; all state changes on rising edge only
// - _MR   in   1      reset, synchronous, active-low; clears Q on rising CP
// - _PE   in   1      parallel enable, active-low; loads D on rising CP
// - CEP   in   1      count enable (parallel), active-high
// - CET   in   1      count enable (trickle), active-high; also gates TC
// - D     in   WIDTH  parallel load data (from hct74157 Y)
// - Q     out  WIDTH  counter value
// - TC    out  1      terminal count = CET & (Q == all ones)
// BEHAVIOUR
// - One clock (CP); reset is synchronous and active-low (_MR). No async paths into Q.
// - Power-up: Q = 'x until first rising CP with _MR=0; TC follows Q (x if Q is x and CET=1).
// - Rising CP priority, evaluated on values sampled at the edge:
//   1. _MR=0              -> Q <= 0 (regardless of _PE, CEP, CET, D)
//   2. _MR=1, _PE=0       -> Q <= D (load overrides count, CEP/CET ignored)
//   3. _MR=1,_PE=1,CEP=1,CET=1 -> Q <= Q+1, modulo 2^WIDTH (all ones wraps to 0)
//   4. otherwise          -> Q holds
// - Latency: Q reflects the operation one CP edge later (plus TPD_CP_Q in timing build).
// - TC combinational from Q and CET: asserts while Q==all ones and CET=1; drops on wrap.
//   CEP does not affect TC. TC is not gated by _MR or _PE.
// - Reset mid-count: _MR low on any edge clears Q that edge; count resumes from 0 on the
//   first edge with _MR=1 and enables high. _MR low between edges has no effect.
// - Load of all ones with CET=1: TC asserts after the load edge.
// - Cascade: stage n CET = stage n-1 TC, all CEP tied; chain counts as one 2*WIDTH counter.
// - Q/D/TC are full WIDTH; no sign handling; D wider values not permitted (port-sized).
// CONFIGURATION
// - HCT74163_TIMING_EN defined: Q updated TPD_CP_Q after CP edge; TC path delayed by
//   TPD_CP_TC from CP-driven Q change and TPD_CET_TC from CET change (transport delay,
//   pulses narrower than delay not filtered). Sampling at edge still uses pre-edge inputs.
// - Not defined: zero-delay model; Q and TC settle in the same timestep as the edge/CET.
//   Functional sequence of Q values identical in both builds.
// TESTING
// - Reset: _MR=0, D=4'hA, _PE=0, one CP edge -> Q=0, TC=0 (reset beats load).
// - Count: _MR=1,_PE=1,CEP=CET=1 from 0, 15 edges -> Q=15, TC=1; 16th edge -> Q=0, TC=0.
// - Load: _PE=0, D=4'h9, CEP=CET=0, one edge -> Q=9; next edge with _PE=1, CEP=CET=1 -> Q=10.
// - Hold/TC gating: Q=15, CEP=0, CET=1 -> Q holds 15, TC=1; CET->0 -> TC=0 (after 14ns in
//   timing build), Q still 15.
// - Mid-count reset: count to Q=6, assert _MR=0 between edges -> Q=6; next edge -> Q=0.
// - Cascade via hct74157: two stages, mux S=1, I1=8'hFE loaded; 2 edges -> Q=8'h00,
//   low TC pulses at FF; timing build: Q lags CP by 20ns, CP->TC 24ns.

Source files
------------

// File: rtl/hct74163.sv
// hct74163: presettable synchronous WIDTH-bit binary counter (74HCT163 behaviour).
// Latency: Q reflects clear/load/count one rising CP edge later; TC is combinational from Q and CET.
// Backpressure: none; CEP & CET gate counting, and cascaded stages ripple-enable through CET/TC.
//
// Ports:
//   CP   in          clock, all state changes on the rising edge
//   _MR  in          synchronous clear, active-low (highest priority)
//   _PE  in          parallel load enable, active-low (beats counting)
//   CEP  in          count enable, parallel
//   CET  in          count enable, trickle; also gates TC
//   D    in  [W-1:0] parallel load data (normally from an hct74157 Y output)
//   Q    out [W-1:0] counter value
//   TC   out         terminal count = CET & (Q == all ones)
//
// Optional build macro HCT74163_TIMING_EN adds transport delays on Q and TC
// (TPD_CP_Q, TPD_CP_TC, TPD_CET_TC, in ns). Without it the model is zero-delay
// and fully synthesizable. The sequence of Q values is identical in both builds.

`timescale 1ns/1ps

module hct74163 #(
  parameter int WIDTH = 4
`ifdef HCT74163_TIMING_EN
  ,
  parameter int TPD_CP_Q   = 20,
  parameter int TPD_CP_TC  = 24,
  parameter int TPD_CET_TC = 14
`endif
) (
  input  logic             CP,
  input  logic             _MR,
  input  logic             _PE,
  input  logic             CEP,
  input  logic             CET,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC
);

  // Internal state. Deliberately has no power-up value: like the chip, Q is
  // undefined until the first edge with _MR low (or a load).
  logic [WIDTH-1:0] q_int;

  // Priority: clear, then load, then count. All controls are sampled at the edge,
  // so a _MR pulse between edges has no effect.
  always_ff @(posedge CP) begin
    if (!_MR) begin
      q_int <= '0;
    end else if (!_PE) begin
      q_int <= D;
    end else if (CEP && CET) begin
      q_int <= q_int + WIDTH'(1);   // wraps modulo 2^WIDTH
    end
  end

`ifdef HCT74163_TIMING_EN
  // Transport delays: every change is scheduled independently, so pulses
  // narrower than the delay propagate rather than being swallowed.
  logic [WIDTH-1:0] q_dly;
  logic             ones_dly;
  logic             cet_dly;

  always @(q_int) q_dly    <= #(TPD_CP_Q)   q_int;
  always @(q_int) ones_dly <= #(TPD_CP_TC)  (&q_int);
  always @(CET)   cet_dly  <= #(TPD_CET_TC) CET;

  assign Q  = q_dly;
  assign TC = cet_dly & ones_dly;
`else
  assign Q  = q_int;
  // CEP does not enter TC; only CET gates it, which is what makes CET/TC
  // ripple cascading work.
  assign TC = CET & (&q_int);
`endif

endmodule

// File: tb/tb_hct74163.sv
// tb_hct74163: directed-vector bench for hct74163 with an arithmetic reference model.
// Inputs change 1 ns after each rising edge; outputs are compared on the falling edge.
// A two-stage cascade fed through a behavioural 2:1 mux checks TC ripple-enable.

`timescale 1ns/1ps

module tb_hct74163;

  logic       clk = 1'b0;
  logic       mr, pe, cep, cet;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc;

  // Cascade: hct74157-style mux selects I0/I1, low stage TC feeds high stage CET.
  logic       c_mr, c_pe, c_cep, c_cet, c_s;
  logic [7:0] c_i0, c_i1, c_y;
  logic [3:0] q_lo, q_hi;
  logic       tc_lo, tc_hi;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hct74163 #(.WIDTH(4)) dut (
    .CP(clk), ._MR(mr), ._PE(pe), .CEP(cep), .CET(cet), .D(d), .Q(q), .TC(tc)
  );

  assign c_y = c_s ? c_i1 : c_i0;

  hct74163 #(.WIDTH(4)) u_lo (
    .CP(clk), ._MR(c_mr), ._PE(c_pe), .CEP(c_cep), .CET(c_cet), .D(c_y[3:0]),
    .Q(q_lo), .TC(tc_lo)
  );

  hct74163 #(.WIDTH(4)) u_hi (
    .CP(clk), ._MR(c_mr), ._PE(c_pe), .CEP(c_cep), .CET(tc_lo), .D(c_y[7:4]),
    .Q(q_hi), .TC(tc_hi)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: plain integer counter, valid once cleared or loaded.
  int m_q   = 0;
  bit m_vld = 1'b0;

  always @(posedge clk) begin
    if (!mr) begin
      m_q   = 0;
      m_vld = 1'b1;
    end else if (!pe) begin
      m_q   = int'(d);
      m_vld = 1'b1;
    end else if (cep && cet) begin
      m_q = (m_q + 1) % 16;
    end
  end

  always @(negedge clk) begin
    if (m_vld) begin
      chk("model_q",  int'(q),  m_q);
      chk("model_tc", int'(tc), (cet && m_q == 15) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v_mr, input logic v_pe, input logic v_cep,
                       input logic v_cet, input logic [3:0] v_d);
    mr = v_mr; pe = v_pe; cep = v_cep; cet = v_cet; d = v_d;
  endtask

  // Directed table: {mr, pe, cep, cet, d}, applied after the count is cleared.
  typedef struct {
    logic       mr, pe, cep, cet;
    logic [3:0] d;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h3};  // load 3
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h0};  // CET low: hold
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h0};  // CEP low: hold
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h0};  // count -> 4
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'hE};  // load beats count -> E
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h0};  // count -> F
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h0};  // wrap -> 0
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h7};  // clear beats load -> 0
  end

  initial begin
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    c_mr = 1'b1; c_pe = 1'b1; c_cep = 1'b0; c_cet = 1'b0;
    c_s = 1'b0; c_i0 = 8'h00; c_i1 = 8'h00;
    tick();

    // Reset beats load.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'hA);
    tick();
    chk("reset_q", int'(q), 0);
    chk("reset_tc", int'(tc), 0);

    // Count 15 edges from 0, then wrap.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
    repeat (15) tick();
    chk("count15_q", int'(q), 15);
    chk("count15_tc", int'(tc), 1);
    tick();
    chk("wrap_q", int'(q), 0);
    chk("wrap_tc", int'(tc), 0);

    // Load 9 with enables low, then count once.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h9);
    tick();
    chk("load_q", int'(q), 9);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
    tick();
    chk("load_inc_q", int'(q), 10);

    // Load all ones with CET=1: TC right after the load edge.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'hF);
    tick();
    chk("load_ff_q", int'(q), 15);
    chk("load_ff_tc", int'(tc), 1);

    // Hold with CEP low, then TC gated off by CET.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
    tick();
    chk("hold_q", int'(q), 15);
    chk("hold_tc", int'(tc), 1);
    cet = 1'b0;
    #1;
    chk("cet_gate_tc", int'(tc), 0);
    chk("cet_gate_q", int'(q), 15);
    tick();

    // Mid-count reset: _MR pulse between edges is ignored.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
    tick();
    mr = 1'b1;
    repeat (6) tick();
    chk("mid_count_q", int'(q), 6);
    mr = 1'b0;
    #2;
    mr = 1'b1;
    #1;
    chk("mr_between_edges_q", int'(q), 6);
    mr = 1'b0;
    tick();
    chk("mid_reset_q", int'(q), 0);
    mr = 1'b1;
    tick();
    chk("resume_q", int'(q), 1);

    // Directed table, checked by the model on every falling edge.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].mr, vecs[i].pe, vecs[i].cep, vecs[i].cet, vecs[i].d);
      tick();
    end
    chk("table_end_q", int'(q), 0);

    // Cascade: load 8'hFE through the mux with S=1, then two count edges.
    c_s = 1'b1; c_i1 = 8'hFE; c_i0 = 8'h12; c_pe = 1'b0;
    tick();
    chk("casc_load", int'({q_hi, q_lo}), 8'hFE);
    c_pe = 1'b0; c_cep = 1'b1; c_cet = 1'b1;
    c_pe = 1'b1;
    #1;
    chk("casc_fe_tc_lo", int'(tc_lo), 0);
    tick();
    chk("casc_ff", int'({q_hi, q_lo}), 8'hFF);
    chk("casc_ff_tc_lo", int'(tc_lo), 1);
    chk("casc_ff_tc_hi", int'(tc_hi), 1);
    tick();
    chk("casc_wrap", int'({q_hi, q_lo}), 8'h00);
    chk("casc_wrap_tc_hi", int'(tc_hi), 0);
    tick();
    chk("casc_01", int'({q_hi, q_lo}), 8'h01);

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
